// File: rtl/vec_ctrl_pkg.sv
// Shared types and constants for the vector execute-stage hazard controller.
package vec_ctrl_pkg;

  localparam int unsigned RA_W_DEF      = 4;
  localparam int unsigned MULTI_LAT_DEF = 4;
  localparam int unsigned ALU_CTRL_W    = 3;
  localparam int unsigned NUM_ALU_OPS   = 8;

  // Vector ALU op codes carried on ALUControlE
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'd1;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'd2;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'd3;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR = 3'd4;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'd5;
  localparam logic [ALU_CTRL_W-1:0] ALU_MUL = 3'd6;
  localparam logic [ALU_CTRL_W-1:0] ALU_MAC = 3'd7;

  // Multiply and multiply-accumulate occupy E for several cycles
  localparam logic [NUM_ALU_OPS-1:0] MULTI_OP_MASK_DEF =
    (NUM_ALU_OPS'(1) << ALU_MUL) | (NUM_ALU_OPS'(1) << ALU_MAC);

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } exec_state_t;

endpackage

// File: rtl/vec_fwd_unit.sv
// Operand forwarding select for both E-stage sources; M result wins over W.
module vec_fwd_unit
  import vec_ctrl_pkg::*;
#(
  parameter int unsigned RA_W = RA_W_DEF
) (
  input  logic [RA_W-1:0] ra1e,
  input  logic [RA_W-1:0] ra2e,
  input  logic [RA_W-1:0] wa3m,
  input  logic [RA_W-1:0] wa3w,
  input  logic            reg_write_m,
  input  logic            reg_write_w,
  output fwd_sel_t        fwd_a,
  output fwd_sel_t        fwd_b
);

  function automatic fwd_sel_t pick(input logic [RA_W-1:0] src);
    if (reg_write_m && (wa3m == src))      return FWD_MEM;
    else if (reg_write_w && (wa3w == src)) return FWD_WB;
    else                                   return FWD_RF;
  endfunction

  // Register 0 is not special: any address match forwards
  always_comb begin
    fwd_a = pick(ra1e);
    fwd_b = pick(ra2e);
  end

endmodule

// File: rtl/vec_exec_hazard_ctrl.sv
// Hazard and sequencing controller for the 8-lane vector execute stage:
// forwarding selects, load-use stall, and multi-cycle ALU op sequencing.
module vec_exec_hazard_ctrl
  import vec_ctrl_pkg::*;
#(
  parameter int unsigned           RA_W          = RA_W_DEF,
  parameter int unsigned           MULTI_LAT     = MULTI_LAT_DEF,
  parameter logic [NUM_ALU_OPS-1:0] MULTI_OP_MASK = MULTI_OP_MASK_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RA_W-1:0]       Ra1D,
  input  logic [RA_W-1:0]       Ra2D,
  input  logic [RA_W-1:0]       Ra1E,
  input  logic [RA_W-1:0]       Ra2E,
  input  logic [RA_W-1:0]       WA3E,
  input  logic [RA_W-1:0]       WA3M,
  input  logic [RA_W-1:0]       WA3W,
  input  logic                  ValidE,
  input  logic                  MemtoRegE,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic [ALU_CTRL_W-1:0] ALUControlE,
  input  logic                  FlushIn,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  FlushE,
  output logic                  FlushM,
  output logic                  AluBusy,
  output logic                  AluDone
);

  // A 2-cycle op still needs one counter bit to hold the value 0
  localparam int unsigned CNT_W = (MULTI_LAT > 2) ? $clog2(MULTI_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULTI_LAT - 2);

  exec_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  fwd_sel_t         fwd_a, fwd_b;
  logic             start, ld_stall, fsm_stall;

  vec_fwd_unit #(.RA_W(RA_W)) u_fwd (
    .ra1e        (Ra1E),
    .ra2e        (Ra2E),
    .wa3m        (WA3M),
    .wa3w        (WA3W),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b)
  );

  // Forward selects ignore the FSM so a held op keeps picking up fresh W data
  assign ForwardAE = 2'(fwd_a);
  assign ForwardBE = 2'(fwd_b);

  // Hazard sources
  assign start    = ValidE & MULTI_OP_MASK[ALUControlE] & ~FlushIn;
  assign ld_stall = ValidE & MemtoRegE & ((WA3E == Ra1D) | (WA3E == Ra2D));

  // State and down-counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and stall/flush combine: FlushIn > multi-cycle stall > load-use
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fsm_stall = 1'b0;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    AluBusy   = 1'b0;
    AluDone   = 1'b0;

    if (rst) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (FlushIn) begin
      FlushE    = 1'b1;
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            fsm_stall = 1'b1;
            state_nxt = BUSY;
            cnt_nxt   = CNT_LOAD;
          end
        end
        BUSY: begin
          AluBusy = 1'b1;
          if (cnt != '0) begin
            fsm_stall = 1'b1;
            cnt_nxt   = cnt - CNT_W'(1);
          end else begin
            AluDone   = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase

      if (fsm_stall) begin
        StallF  = 1'b1;
        StallD  = 1'b1;
        StallE  = 1'b1;
        FlushM  = 1'b1;
        AluBusy = 1'b1;
      end else if (ld_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

endmodule
